// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM-stage load/store port.
// Optional build macro DMEM_RANGE_CHECK_EN flags accesses beyond DEPTH_WORDS*4 as errors.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        stall_o
);

    localparam int unsigned IdxW        = $clog2(DEPTH_WORDS);
    localparam bit          SingleCycle = (LATENCY == 1);
    localparam logic [3:0]  CntLoad     = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        ack_q;
    logic        err_q;
    logic [31:0] rdata_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic            eff_we;
    logic [31:0]     eff_addr;
    logic [31:0]     eff_wdata;
    logic [IdxW-1:0] idx;
    logic            enter_resp;
    logic            range_err;
    logic            bad;

    // With LATENCY=1 the IDLE->RESP edge must use the live inputs, not the captured copy.
    always_comb begin
        eff_we    = we_q;
        eff_addr  = addr_q;
        eff_wdata = wdata_q;
        if (state_q == StIdle) begin
            eff_we    = we_i;
            eff_addr  = addr_i;
            eff_wdata = wdata_i;
        end
        idx        = eff_addr[IdxW+1:2];
        enter_resp = (SingleCycle && state_q == StIdle && req_i) ||
                     (state_q == StWait && cnt_q == 4'd0);
        bad        = (eff_addr[1:0] != 2'b00) || range_err;
    end

`ifdef DMEM_RANGE_CHECK_EN
    localparam logic [31:0] RangeLimit = 32'(DEPTH_WORDS * 4);
    assign range_err = (eff_addr >= RangeLimit);
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^eff_addr[31:IdxW+2];
    assign range_err      = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            if (enter_resp) begin
                ack_q <= 1'b1;
                err_q <= bad;
                if (!eff_we && !bad) begin
                    rdata_q <= mem[idx];
                end
            end
            unique case (state_q)
                StIdle: begin
                    if (req_i) begin
                        we_q    <= we_i;
                        addr_q  <= addr_i;
                        wdata_q <= wdata_i;
                        cnt_q   <= CntLoad;
                        state_q <= SingleCycle ? StResp : StWait;
                    end
                end
                StWait: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        state_q <= StResp;
                    end
                end
                StResp:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    // Array is never reset; gating on rst_i keeps an in-reset edge from committing.
    always_ff @(posedge clk_i) begin
        if (rst_i && enter_resp && eff_we && !bad) begin
            mem[idx] <= eff_wdata;
        end
    end

    // Read data is held across writes/errors but masked to zero during an error response.
    assign ack_o   = ack_q;
    assign err_o   = err_q;
    assign rdata_o = err_q ? 32'd0 : rdata_q;
    assign stall_o = req_i & ~ack_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: LATENCY=3 main instance plus a LATENCY=1 instance.
module tb_dmem_responder;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, req1;
    logic        we;
    logic [31:0] addr, wdata;
    logic        ack, err, stall;
    logic [31:0] rdata;
    logic        ack1, err1, stall1;
    logic [31:0] rdata1;

    int n_checks = 0;
    int n_errs   = 0;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] exp_mem [int];
    logic [31:0] last_rd = 32'd0;
    logic        prev_ack = 1'b0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
        .clk_i   (clk),
        .rst_i   (rst_n),
        .req_i   (req),
        .we_i    (we),
        .addr_i  (addr),
        .wdata_i (wdata),
        .ack_o   (ack),
        .rdata_o (rdata),
        .err_o   (err),
        .stall_o (stall)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) dut1 (
        .clk_i   (clk),
        .rst_i   (rst_n),
        .req_i   (req1),
        .we_i    (we),
        .addr_i  (addr),
        .wdata_i (wdata),
        .ack_o   (ack1),
        .rdata_o (rdata1),
        .err_o   (err1),
        .stall_o (stall1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: compute the response when the request is driven.
    task automatic sb_push(input logic w, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        logic b;
        int   i;
        b = (a[1:0] != 2'b00);
`ifdef DMEM_RANGE_CHECK_EN
        b = b || (a >= 32'h1000);
`endif
        i = int'(a[11:2]);
        e.err = b;
        if (b) begin
            e.rdata = 32'd0;
        end else if (w) begin
            exp_mem[i] = d;
            e.rdata = last_rd;
        end else begin
            last_rd = exp_mem.exists(i) ? exp_mem[i] : 32'hxxxxxxxx;
            e.rdata = last_rd;
        end
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n && ack) begin
            check_eq("ack_consecutive", 32'(prev_ack), 32'd0);
            if (sb_q.size() == 0) begin
                check_eq("unexpected_ack", 32'(ack), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_eq("err", 32'(err), 32'(e.err));
                check_eq("rdata", rdata, e.rdata);
            end
        end
        prev_ack = rst_n ? ack : 1'b0;
    end

    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input bit timing);
        int ack_cyc;
        @(posedge clk); #1;
        req = 1'b1; we = w; addr = a; wdata = d;
        sb_push(w, a, d);
        ack_cyc = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (timing && k <= LAT) check_eq("stall", 32'(stall), 32'(k < LAT));
            if (ack) begin
                ack_cyc = k;
                break;
            end
        end
        if (timing || ack_cyc < 0) check_eq("ack_cycle", 32'(ack_cyc), 32'(LAT));
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    initial begin
        int acks[$];
        int n_rst_acks;

        rst_n = 1'b0; req = 1'b1; req1 = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0;
        repeat (2) @(negedge clk);
        check_eq("rst_ack", 32'(ack), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_rdata", rdata, 32'd0);
        check_eq("rst_stall_hi", 32'(stall), 32'd1);
        req = 1'b0;
        #1 check_eq("rst_stall_lo", 32'(stall), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Preload locations whose prior contents are checked later.
        access(1'b1, 32'h20, 32'h0, 1'b0);
        access(1'b1, 32'h0, 32'h0, 1'b0);

        access(1'b1, 32'h10, 32'hDEADBEEF, 1'b1);
        access(1'b0, 32'h10, 32'h0, 1'b1);
        access(1'b1, 32'h14, 32'h1, 1'b0);
        access(1'b1, 32'h13, 32'h12345678, 1'b0);
        access(1'b0, 32'h10, 32'h0, 1'b0);

        // Reset pulse while the write is in WAIT.
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        rst_n = 1'b0; req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_rst_acks = 0;
        repeat (8) begin
            @(negedge clk);
            if (ack) n_rst_acks++;
        end
        check_eq("rst_no_ack", 32'(n_rst_acks), 32'd0);
        access(1'b0, 32'h20, 32'h0, 1'b0);

        access(1'b1, 32'h1000, 32'hA5A5A5A5, 1'b0);
        access(1'b0, 32'h0, 32'h0, 1'b0);

        // Back-to-back reads with req held.
        @(posedge clk); #1;
        req = 1'b1; we = 1'b0; addr = 32'h10;
        sb_push(1'b0, 32'h10, 32'h0);
        sb_push(1'b0, 32'h10, 32'h0);
        for (int k = 0; k < 20 && acks.size() < 2; k++) begin
            @(negedge clk);
            if (ack) acks.push_back(k);
        end
        @(posedge clk); #1 req = 1'b0;
        check_eq("b2b_ack_count", 32'(acks.size()), 32'd2);
        if (acks.size() == 2) begin
            check_eq("b2b_ack0", 32'(acks[0]), 32'd3);
            check_eq("b2b_ack1", 32'(acks[1]), 32'd7);
        end

        acks.delete();
        @(posedge clk); #1;
        req1 = 1'b1; we = 1'b0; addr = 32'h0;
        for (int k = 0; k < 20 && acks.size() < 2; k++) begin
            @(negedge clk);
            if (ack1) acks.push_back(k);
        end
        @(posedge clk); #1 req1 = 1'b0;
        check_eq("lat1_ack_count", 32'(acks.size()), 32'd2);
        if (acks.size() == 2) begin
            check_eq("lat1_ack0", 32'(acks[0]), 32'd1);
            check_eq("lat1_ack1", 32'(acks[1]), 32'd3);
        end

        repeat (3) @(negedge clk);
        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
